fft_dac_sched: RTL

FFT_DAC_SCHED -- requirements
Module: fft_dac_sched

---
 rtl/fft_dac_pkg.sv | 15 +
 rtl/fft_dac_rr_arb.sv | 33 +++
 rtl/fft_dac_sched.sv | 123 ++++++++++++
 3 files changed

// File: rtl/fft_dac_pkg.sv
// Shared types and defaults for the FFT/tone DAC slot scheduler.
// DAC_HOLD_LAST_EN (optional define) re-sends the last sample on empty slots.
package fft_dac_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT_START,
        S_WAIT_DONE
    } state_t;

    localparam int RATE_DIV_DEF  = 1000;
    localparam int START_TMO_DEF = 4;

endpackage

// File: rtl/fft_dac_rr_arb.sv
// Two-way round-robin arbiter; the pointer moves only when a grant is taken.
module fft_dac_rr_arb
    import fft_dac_pkg::*;
(
    input  logic       iCLK,
    input  logic       iRESET,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt
);

    logic prio_b;

    always_comb begin
        gnt = 2'b00;
        unique case (1'b1)
            (req == 2'b11): gnt = prio_b ? 2'b10 : 2'b01;
            (req == 2'b01): gnt = 2'b01;
            (req == 2'b10): gnt = 2'b10;
            default:        gnt = 2'b00;
        endcase
    end

    // prio_b clear means A wins a tie
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            prio_b <= 1'b0;
        end else if (en && (gnt != 2'b00)) begin
            prio_b <= gnt[0];
        end
    end

endmodule

// File: rtl/fft_dac_sched.sv
// DAC slot scheduler: per-slot arbitration between FFT and tone sources.
// DAC_HOLD_LAST_EN: when defined, an empty slot re-sends the last sample.
module fft_dac_sched
    import fft_dac_pkg::*;
#(
    parameter int RATE_DIV  = RATE_DIV_DEF,
    parameter int START_TMO = START_TMO_DEF
) (
    input  logic        iCLK,
    input  logic        iRESET,
    input  logic        iA_VALID,
    input  logic [15:0] iA_DATA,
    output logic        oA_READY,
    input  logic        iB_VALID,
    input  logic [15:0] iB_DATA,
    output logic        oB_READY,
    output logic        oEN,
    output logic [15:0] oDATA,
    input  logic        iDAC_CS,
    output logic        oBUSY,
    output logic        oERR,
    output logic [7:0]  oOVR
);

    localparam logic [15:0] CNT_MAX  = 16'(RATE_DIV - 1);
    localparam logic [15:0] TMO_LAST = 16'(START_TMO - 1);
`ifdef DAC_HOLD_LAST_EN
    localparam bit HOLD_LAST = 1'b1;
`else
    localparam bit HOLD_LAST = 1'b0;
`endif

    state_t      state;
    logic [15:0] cnt;
    logic [15:0] tmo;
    logic        tick;
    logic        pend;
    logic        arb_en;
    logic [1:0]  gnt;

    assign arb_en   = (state == S_IDLE) && (tick || pend);
    assign oA_READY = arb_en & gnt[0];
    assign oB_READY = arb_en & gnt[1];

    fft_dac_rr_arb u_arb (
        .iCLK   (iCLK),
        .iRESET (iRESET),
        .req    ({iB_VALID, iA_VALID}),
        .en     (arb_en),
        .gnt    (gnt)
    );

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            tick <= (cnt == CNT_MAX);
            cnt  <= (cnt == CNT_MAX) ? '0 : cnt + 16'd1;
        end
    end

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            state <= S_IDLE;
            pend  <= 1'b0;
            tmo   <= '0;
            oEN   <= 1'b0;
            oDATA <= '0;
            oBUSY <= 1'b0;
            oERR  <= 1'b0;
            oOVR  <= '0;
        end else begin
            oEN <= 1'b0;
            // a slot boundary while busy is deferred once, then counted as lost
            if (tick && (state != S_IDLE)) begin
                if (!pend)
                    pend <= 1'b1;
                else if (oOVR != 8'hFF)
                    oOVR <= oOVR + 8'd1;
            end
            unique case (state)
                S_IDLE: begin
                    if (tick || pend) begin
                        pend <= 1'b0;
                        if (gnt[0])
                            oDATA <= iA_DATA;
                        else if (gnt[1])
                            oDATA <= iB_DATA;
                        if ((gnt != 2'b00) || HOLD_LAST) begin
                            state <= S_LOAD;
                            oEN   <= 1'b1;
                            oBUSY <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    state <= S_WAIT_START;
                    tmo   <= '0;
                end
                S_WAIT_START: begin
                    if (!iDAC_CS) begin
                        state <= S_WAIT_DONE;
                    end else if (tmo == TMO_LAST) begin
                        oERR  <= 1'b1;
                        state <= S_IDLE;
                        oBUSY <= 1'b0;
                    end else begin
                        tmo <= tmo + 16'd1;
                    end
                end
                S_WAIT_DONE: begin
                    if (iDAC_CS) begin
                        state <= S_IDLE;
                        oBUSY <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
